axis_axil_cmd_master: RTL and testbench
=======================================

Name: axis_axil_cmd_master

Overview:
- Upstream AXI-Lite master for the peripheral crossbar.
- Takes a byte-stream command protocol on an AXI-Stream slave port, for example from a host UART RX or an Ethernet payload stream.
- Issues single AXI-Lite read or write transactions into one crossbar slave port.
- Returns status and read data as a byte stream on an AXI-Stream master port.

Parameters:
- AXIL_ADDR_WIDTH, 32, AXI-Lite address width. Only 32 is supported; 4 address bytes per frame.
- AXIL_DATA_WIDTH, 32, AXI-Lite data width. Only 32 is supported; 4 data bytes per frame.
- TIMEOUT_CYCLES, 1024, maximum wait for an AXI-Lite handshake. Used only with the optional feature.

Ports:
- clk_i in 1: single clock.
- arstn_i in 1: synchronous, active-low reset.
- s_axis_tdata in 8: command byte.
- s_axis_tvalid in 1: command byte valid.
- s_axis_tready out 1: command byte accepted.
- m_axis_tdata out 8: response byte.
- m_axis_tvalid out 1: response byte valid.
- m_axis_tlast out 1: marks the last byte of a response.
- m_axis_tready in 1: response byte accepted.
- m_axil_awaddr out 32; m_axil_awvalid out 1; m_axil_awready in 1.
- m_axil_wdata out 32; m_axil_wstrb out 4, always 4'hF; m_axil_wvalid out 1; m_axil_wready in 1.
- m_axil_bresp in 2; m_axil_bvalid in 1; m_axil_bready out 1.
- m_axil_araddr out 32; m_axil_arvalid out 1; m_axil_arready in 1.
- m_axil_rdata in 32; m_axil_rresp in 2; m_axil_rvalid in 1; m_axil_rready out 1.

Behaviour:
- Reset (arstn_i=0 at a clk_i edge):
  - FSM goes to IDLE.
  - All valid and ready outputs are 0; tdata, tlast, addresses and wdata are 0; byte counter is 0.
  - Reset mid-transaction drops every valid on the next edge. No response is sent for the aborted command.
- Frame format, multi-byte fields big-endian (MSB byte first):
  - Write: 0x01, ADDR[4], DATA[4].
  - Read: 0x02, ADDR[4].
- FSM states: IDLE, GET_ADDR, GET_DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, TX_STATUS, TX_DATA.
- s_axis_tready is 1 only in IDLE, GET_ADDR and GET_DATA. A byte is consumed when tvalid&&tready.
- IDLE, on byte 0x01 or 0x02: latch the opcode and go to GET_ADDR.
- IDLE, on any other byte: load status 0xEE and go to TX_STATUS. The byte is dropped and the response is a single byte with tlast=1.
- GET_ADDR: shift in 4 bytes into the address register.
  - After the 4th byte: write goes to GET_DATA; read goes to RD_REQ.
- GET_DATA: shift in 4 bytes, then go to WR_REQ.
- WR_REQ:
  - awvalid and wvalid are asserted together on entry.
  - Each one deasserts on the cycle after its own handshake.
  - When both are done, go to WR_RESP. This holds whether the handshakes happen in the same cycle or in either order.
- WR_RESP: bready=1. On bvalid, latch status = {6'b0, bresp} and go to TX_STATUS.
- RD_REQ: arvalid=1 until arready, then go to RD_RESP.
- RD_RESP: rready=1. On rvalid, latch rdata and status = {6'b0, rresp}, then go to TX_STATUS.
- TX_STATUS:
  - m_axis_tvalid=1 with the status byte, held stable until tready.
  - tlast=1 for writes, error bytes and timeouts; tlast=0 for reads.
  - After acceptance: a read that completed goes to TX_DATA; anything else goes to IDLE.
- TX_DATA:
  - Send rdata MSB byte first, 4 bytes.
  - tlast=1 on the 4th byte. Data and tlast are held stable while tvalid&&!tready.
  - Read data is sent even when rresp is non-OKAY.
  - After the last byte, go to IDLE.
- Throughput: one command in flight at a time. The first response byte is presented on the cycle after the B or R handshake.
- Never asserts awvalid, wvalid or arvalid while waiting for a response; at most one outstanding transaction.

Optional Feature:
- Macro: AXIS_AXIL_CMD_MASTER_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to WR_REQ or RD_REQ and counts every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When it reaches TIMEOUT_CYCLES-1 without completion, the FSM drops all AXI-Lite valids and readies on the next edge.
  - It then loads status 0xFF and goes to TX_STATUS with tlast=1. No read data bytes are sent.
- Disabled: no counter; the FSM waits indefinitely.

Test Plan:
- Write: bytes 01 40 00 00 04 DE AD BE EF.
  - Expect awaddr=0x40000004, wdata=0xDEADBEEF, wstrb=F.
  - Slave bresp=00 → single response byte 0x00 with tlast=1.
- Read: bytes 02 40 00 00 08, slave returns rdata=0x12345678, rresp=00.
  - Expect response 00 12 34 56 78, with tlast only on 0x78.
- Handshake ordering:
  - wready 3 cycles before awready: each valid drops independently, exactly one B wait.
  - awready and wready in the same cycle: same result.
- Bad opcode 0x7F → response 0xEE with tlast=1. Next frame 02 ... is decoded correctly.
- Backpressure and errors:
  - m_axis_tready low for 5 cycles per byte: data stays stable, no byte lost.
  - rresp=10 → status 0x02 followed by 4 data bytes.
- Timeout (macro on, TIMEOUT_CYCLES=16): arready held 0 → arvalid drops after 16 cycles, response 0xFF with tlast=1.
- Reset mid-write: reset asserted during WR_RESP → all valids 0 on the next edge, no response byte. A following write completes normally.

Source files
------------

// File: rtl/axis_axil_cmd_master.sv
// Byte-stream command front end that issues single AXI-Lite reads/writes and streams back status/data.
// Optional handshake watchdog: define AXIS_AXIL_CMD_MASTER_TIMEOUT_EN.
module axis_axil_cmd_master #(
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic [7:0]                 s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic [AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic                       m_axil_awvalid,
  input  logic                       m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0] m_axil_wdata,
  output logic [3:0]                 m_axil_wstrb,
  output logic                       m_axil_wvalid,
  input  logic                       m_axil_wready,
  input  logic [1:0]                 m_axil_bresp,
  input  logic                       m_axil_bvalid,
  output logic                       m_axil_bready,
  output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
  output logic                       m_axil_arvalid,
  input  logic                       m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]                 m_axil_rresp,
  input  logic                       m_axil_rvalid,
  output logic                       m_axil_rready
);

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, TX_STATUS, TX_DATA
  } state_t;

  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam logic [7:0] ST_BAD_OP  = 8'hEE;
  localparam logic [7:0] ST_TIMEOUT = 8'hFF;

  if (AXIL_ADDR_WIDTH != 32 || AXIL_DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("axis_axil_cmd_master: only 32-bit address/data and TIMEOUT_CYCLES >= 2 are supported");
  end

  state_t                     state;
  logic                       is_read;
  logic                       send_data;
  logic                       aw_done;
  logic                       w_done;
  logic [1:0]                 byte_cnt;
  logic [AXIL_ADDR_WIDTH-1:0] addr_q;
  logic [AXIL_DATA_WIDTH-1:0] wdata_q;
  logic [AXIL_DATA_WIDTH-1:0] rdata_q;

  logic s_fire;
  logic m_fire;
  logic aw_ok;
  logic w_ok;

  assign s_fire = s_axis_tvalid && s_axis_tready;
  assign m_fire = m_axis_tvalid && m_axis_tready;
  // A channel is finished once its handshake has happened, either earlier or on this edge.
  assign aw_ok  = aw_done || (m_axil_awvalid && m_axil_awready);
  assign w_ok   = w_done  || (m_axil_wvalid  && m_axil_wready);

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = 4'hF;

`ifdef AXIS_AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int              TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            waiting;
  logic            done_now;
  logic            to_hit;

  assign waiting  = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_RESP);
  // Completion on the same edge as expiry wins over the timeout.
  assign done_now = ((state == WR_REQ)  && aw_ok && w_ok) ||
                    ((state == WR_RESP) && m_axil_bvalid) ||
                    ((state == RD_REQ)  && m_axil_arready) ||
                    ((state == RD_RESP) && m_axil_rvalid);
  assign to_hit   = waiting && !done_now && (to_cnt == TO_LAST);
`endif

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state          <= IDLE;
      s_axis_tready  <= 1'b0;
      m_axis_tdata   <= 8'h00;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      byte_cnt       <= 2'd0;
      is_read        <= 1'b0;
      send_data      <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
`ifdef AXIS_AXIL_CMD_MASTER_TIMEOUT_EN
      to_cnt         <= '0;
`endif
    end else begin
`ifdef AXIS_AXIL_CMD_MASTER_TIMEOUT_EN
      to_cnt <= to_cnt + 1'b1;
      if (to_hit) begin
        m_axil_awvalid <= 1'b0;
        m_axil_wvalid  <= 1'b0;
        m_axil_bready  <= 1'b0;
        m_axil_arvalid <= 1'b0;
        m_axil_rready  <= 1'b0;
        m_axis_tdata   <= ST_TIMEOUT;
        m_axis_tlast   <= 1'b1;
        m_axis_tvalid  <= 1'b1;
        send_data      <= 1'b0;
        state          <= TX_STATUS;
      end else
`endif
      case (state)
        IDLE: begin
          s_axis_tready <= 1'b1;
          if (s_fire) begin
            if (s_axis_tdata == OP_WRITE || s_axis_tdata == OP_READ) begin
              is_read  <= (s_axis_tdata == OP_READ);
              byte_cnt <= 2'd0;
              state    <= GET_ADDR;
            end else begin
              s_axis_tready <= 1'b0;
              m_axis_tdata  <= ST_BAD_OP;
              m_axis_tlast  <= 1'b1;
              m_axis_tvalid <= 1'b1;
              send_data     <= 1'b0;
              state         <= TX_STATUS;
            end
          end
        end

        GET_ADDR: begin
          if (s_fire) begin
            addr_q   <= {addr_q[AXIL_ADDR_WIDTH-9:0], s_axis_tdata};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              byte_cnt <= 2'd0;
              if (is_read) begin
                s_axis_tready  <= 1'b0;
                m_axil_arvalid <= 1'b1;
`ifdef AXIS_AXIL_CMD_MASTER_TIMEOUT_EN
                to_cnt         <= '0;
`endif
                state          <= RD_REQ;
              end else begin
                state <= GET_DATA;
              end
            end
          end
        end

        GET_DATA: begin
          if (s_fire) begin
            wdata_q  <= {wdata_q[AXIL_DATA_WIDTH-9:0], s_axis_tdata};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              byte_cnt       <= 2'd0;
              s_axis_tready  <= 1'b0;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              aw_done        <= 1'b0;
              w_done         <= 1'b0;
`ifdef AXIS_AXIL_CMD_MASTER_TIMEOUT_EN
              to_cnt         <= '0;
`endif
              state          <= WR_REQ;
            end
          end
        end

        WR_REQ: begin
          if (m_axil_awvalid && m_axil_awready) begin
            m_axil_awvalid <= 1'b0;
            aw_done        <= 1'b1;
          end
          if (m_axil_wvalid && m_axil_wready) begin
            m_axil_wvalid <= 1'b0;
            w_done        <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            m_axil_bready <= 1'b1;
            state         <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            m_axis_tdata  <= {6'b0, m_axil_bresp};
            m_axis_tlast  <= 1'b1;
            m_axis_tvalid <= 1'b1;
            send_data     <= 1'b0;
            state         <= TX_STATUS;
          end
        end

        RD_REQ: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            rdata_q       <= m_axil_rdata;
            m_axis_tdata  <= {6'b0, m_axil_rresp};
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b1;
            send_data     <= 1'b1;
            state         <= TX_STATUS;
          end
        end

        TX_STATUS: begin
          if (m_fire) begin
            if (send_data) begin
              m_axis_tdata <= rdata_q[AXIL_DATA_WIDTH-1 -: 8];
              rdata_q      <= {rdata_q[AXIL_DATA_WIDTH-9:0], 8'h00};
              m_axis_tlast <= 1'b0;
              byte_cnt     <= 2'd0;
              state        <= TX_DATA;
            end else begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              s_axis_tready <= 1'b1;
              state         <= IDLE;
            end
          end
        end

        TX_DATA: begin
          // rdata_q is pre-shifted so its top byte is always the next one to present.
          if (m_fire) begin
            if (byte_cnt == 2'd3) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              s_axis_tready <= 1'b1;
              send_data     <= 1'b0;
              state         <= IDLE;
            end else begin
              m_axis_tdata <= rdata_q[AXIL_DATA_WIDTH-1 -: 8];
              rdata_q      <= {rdata_q[AXIL_DATA_WIDTH-9:0], 8'h00};
              m_axis_tlast <= (byte_cnt == 2'd2);
              byte_cnt     <= byte_cnt + 2'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_axil_cmd_master.sv
// Directed bench for axis_axil_cmd_master: command frames in, AXI-Lite slave model, response bytes out.
`timescale 1ns/1ps
module tb_axis_axil_cmd_master;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [31:0] m_axil_awaddr;
  logic        m_axil_awvalid;
  logic        m_axil_awready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid;
  logic        m_axil_wready;
  logic [1:0]  m_axil_bresp;
  logic        m_axil_bvalid;
  logic        m_axil_bready;
  logic [31:0] m_axil_araddr;
  logic        m_axil_arvalid;
  logic        m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid;
  logic        m_axil_rready;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  axis_axil_cmd_master #(
    .AXIL_ADDR_WIDTH(32),
    .AXIL_DATA_WIDTH(32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i         (clk_i),
    .arstn_i       (arstn_i),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .m_axil_awaddr (m_axil_awaddr),
    .m_axil_awvalid(m_axil_awvalid),
    .m_axil_awready(m_axil_awready),
    .m_axil_wdata  (m_axil_wdata),
    .m_axil_wstrb  (m_axil_wstrb),
    .m_axil_wvalid (m_axil_wvalid),
    .m_axil_wready (m_axil_wready),
    .m_axil_bresp  (m_axil_bresp),
    .m_axil_bvalid (m_axil_bvalid),
    .m_axil_bready (m_axil_bready),
    .m_axil_araddr (m_axil_araddr),
    .m_axil_arvalid(m_axil_arvalid),
    .m_axil_arready(m_axil_arready),
    .m_axil_rdata  (m_axil_rdata),
    .m_axil_rresp  (m_axil_rresp),
    .m_axil_rvalid (m_axil_rvalid),
    .m_axil_rready (m_axil_rready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("s_tready", 32'(s_axis_tready), 32'd1);
    @(negedge clk_i);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h01);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h02);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
  endtask

  task automatic wr_slave(input logic [31:0] ea, input logic [31:0] ed, input int aw_dly,
                          input int w_dly, input bit do_b, input logic [1:0] resp);
    int c = 0;
    bit aw_ok = 1'b0;
    bit w_ok  = 1'b0;
    check("awvalid", 32'(m_axil_awvalid), 32'd1);
    check("wvalid", 32'(m_axil_wvalid), 32'd1);
    check("awaddr", m_axil_awaddr, ea);
    check("wdata", m_axil_wdata, ed);
    check("wstrb", 32'(m_axil_wstrb), 32'hF);
    while (!(aw_ok && w_ok) && c < 20) begin
      m_axil_awready = !aw_ok && (c >= aw_dly);
      m_axil_wready  = !w_ok && (c >= w_dly);
      @(negedge clk_i);
      if (m_axil_awready) aw_ok = 1'b1;
      if (m_axil_wready) w_ok = 1'b1;
      check("awvalid_state", 32'(m_axil_awvalid), 32'(!aw_ok));
      check("wvalid_state", 32'(m_axil_wvalid), 32'(!w_ok));
      c++;
    end
    m_axil_awready = 1'b0;
    m_axil_wready  = 1'b0;
    check("bready", 32'(m_axil_bready), 32'd1);
    if (do_b) begin
      repeat (2) @(negedge clk_i);
      check("bready_hold", 32'(m_axil_bready), 32'd1);
      check("no_req_in_b", 32'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}), 32'd0);
      m_axil_bresp  = resp;
      m_axil_bvalid = 1'b1;
      @(negedge clk_i);
      m_axil_bvalid = 1'b0;
      check("bready_drop", 32'(m_axil_bready), 32'd0);
      check("b_first_byte_lat", 32'(m_axis_tvalid), 32'd1);
    end
  endtask

  task automatic rd_slave(input logic [31:0] ea, input int ar_dly, input logic [31:0] data,
                          input logic [1:0] resp);
    int n = 0;
    while (!m_axil_arvalid && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("arvalid", 32'(m_axil_arvalid), 32'd1);
    check("araddr", m_axil_araddr, ea);
    repeat (ar_dly) @(negedge clk_i);
    check("arvalid_hold", 32'(m_axil_arvalid), 32'd1);
    m_axil_arready = 1'b1;
    @(negedge clk_i);
    m_axil_arready = 1'b0;
    check("arvalid_drop", 32'(m_axil_arvalid), 32'd0);
    check("rready", 32'(m_axil_rready), 32'd1);
    m_axil_rdata  = data;
    m_axil_rresp  = resp;
    m_axil_rvalid = 1'b1;
    @(negedge clk_i);
    m_axil_rvalid = 1'b0;
    check("rready_drop", 32'(m_axil_rready), 32'd0);
    check("r_first_byte_lat", 32'(m_axis_tvalid), 32'd1);
  endtask

  task automatic recv_byte(input logic [7:0] exp_d, input bit exp_last, input int stall,
                           input string tag);
    int n = 0;
    while (!m_axis_tvalid && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_vld"}, 32'(m_axis_tvalid), 32'd1);
    repeat (stall) @(negedge clk_i);
    check({tag, "_data"}, 32'(m_axis_tdata), 32'(exp_d));
    check({tag, "_last"}, 32'(m_axis_tlast), 32'(exp_last));
    m_axis_tready = 1'b1;
    @(negedge clk_i);
    m_axis_tready = 1'b0;
  endtask

  task automatic recv_read(input logic [7:0] st, input logic [31:0] d, input int stall);
    recv_byte(st, 1'b0, stall, "rd_status");
    recv_byte(d[31:24], 1'b0, stall, "rd_b0");
    recv_byte(d[23:16], 1'b0, stall, "rd_b1");
    recv_byte(d[15:8], 1'b0, stall, "rd_b2");
    recv_byte(d[7:0], 1'b1, stall, "rd_b3");
    check("rd_end", 32'(m_axis_tvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    arstn_i        = 1'b0;
    s_axis_tdata   = 8'h00;
    s_axis_tvalid  = 1'b0;
    m_axis_tready  = 1'b0;
    m_axil_awready = 1'b0;
    m_axil_wready  = 1'b0;
    m_axil_bresp   = 2'b00;
    m_axil_bvalid  = 1'b0;
    m_axil_arready = 1'b0;
    m_axil_rdata   = 32'h0;
    m_axil_rresp   = 2'b00;
    m_axil_rvalid  = 1'b0;
    repeat (3) @(negedge clk_i);

    // reset state
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_m_axis", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 32'd0);
    check("rst_axil_ctl", 32'({m_axil_awvalid, m_axil_wvalid, m_axil_bready,
                               m_axil_arvalid, m_axil_rready}), 32'd0);
    check("rst_awaddr", m_axil_awaddr, 32'd0);
    check("rst_wdata", m_axil_wdata, 32'd0);
    arstn_i = 1'b1;
    @(negedge clk_i);

    // basic write, AW and W accepted together
    send_write(32'h4000_0004, 32'hDEAD_BEEF);
    wr_slave(32'h4000_0004, 32'hDEAD_BEEF, 0, 0, 1'b1, 2'b00);
    recv_byte(8'h00, 1'b1, 0, "wr1");
    check("wr1_end", 32'(m_axis_tvalid), 32'd0);

    // basic read
    send_read(32'h4000_0008);
    rd_slave(32'h4000_0008, 0, 32'h1234_5678, 2'b00);
    recv_read(8'h00, 32'h1234_5678, 0);

    // W accepted three cycles before AW
    send_write(32'h0000_0010, 32'hA5A5_5A5A);
    wr_slave(32'h0000_0010, 32'hA5A5_5A5A, 3, 0, 1'b1, 2'b00);
    recv_byte(8'h00, 1'b1, 0, "wr_w_first");

    // AW accepted before W, SLVERR response
    send_write(32'h0000_0014, 32'h0102_0304);
    wr_slave(32'h0000_0014, 32'h0102_0304, 0, 2, 1'b1, 2'b10);
    recv_byte(8'h02, 1'b1, 0, "wr_aw_first");

    // both late but in the same cycle
    send_write(32'h0000_0018, 32'h0BAD_F00D);
    wr_slave(32'h0000_0018, 32'h0BAD_F00D, 2, 2, 1'b1, 2'b00);
    recv_byte(8'h00, 1'b1, 0, "wr_same");
    check("wr_same_end", 32'(m_axis_tvalid), 32'd0);

    // bad opcode, then a read must still decode
    send_byte(8'h7F);
    recv_byte(8'hEE, 1'b1, 0, "bad_op");
    check("bad_op_end", 32'(m_axis_tvalid), 32'd0);
    send_read(32'h4000_000C);
    rd_slave(32'h4000_000C, 1, 32'hCAFE_F00D, 2'b00);
    recv_read(8'h00, 32'hCAFE_F00D, 0);

    // response backpressure with SLVERR read
    send_read(32'h0000_0020);
    rd_slave(32'h0000_0020, 2, 32'h89AB_CDEF, 2'b10);
    recv_read(8'h02, 32'h89AB_CDEF, 5);

`ifdef AXIS_AXIL_CMD_MASTER_TIMEOUT_EN
    // AR never accepted
    send_read(32'h0000_0030);
    n = 0;
    while (m_axil_arvalid && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    check("to_arvalid_cycles", 32'(n), 32'd16);
    check("to_rready", 32'(m_axil_rready), 32'd0);
    recv_byte(8'hFF, 1'b1, 0, "to_status");
    check("to_no_data", 32'(m_axis_tvalid), 32'd0);
`endif

    // reset while waiting for B
    send_write(32'h0000_0050, 32'h1122_3344);
    wr_slave(32'h0000_0050, 32'h1122_3344, 0, 0, 1'b0, 2'b00);
    arstn_i = 1'b0;
    @(negedge clk_i);
    check("midrst_ctl", 32'({m_axil_awvalid, m_axil_wvalid, m_axil_bready,
                             m_axil_arvalid, m_axil_rready}), 32'd0);
    check("midrst_m_axis", 32'({m_axis_tvalid, s_axis_tready}), 32'd0);
    arstn_i = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (m_axis_tvalid) n++;
    end
    check("midrst_no_resp", 32'(n), 32'd0);
    send_write(32'h0000_0054, 32'h5566_7788);
    wr_slave(32'h0000_0054, 32'h5566_7788, 1, 0, 1'b1, 2'b00);
    recv_byte(8'h00, 1'b1, 0, "post_rst_wr");
    check("post_rst_end", 32'(m_axis_tvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
